fa_64bit_sync: RTL and testbench
================================

// Module: fa_64bit_sync
// PURPOSE
// - Registered 64-bit binary adder: {Carry, Sum} = A + B + Cin.
// - Adder core of the ALU execute stage in the 5-stage pipeline; the result is
//   captured on the clock edge so it aligns with the EX/MEM pipeline register.
// - The core is 16 cascaded 4-bit carry-lookahead groups built from full-adder
//   cells, with the carry rippling between groups.
// PARAMETERS
// - WIDTH  64  operand/sum width; only 64 is required to be supported and verified.
// PORTS
// - clk    in   1      clock; all state updates on the rising edge
// - rst    in   1      reset; asynchronous, active-high
// - A      in   64     operand A, unsigned/two's-complement agnostic
// - B      in   64     operand B
// - Cin    in   1      carry-in into bit 0
// - Sum    out  64     registered sum, bits [63:0] of A+B+Cin
// - Carry  out  1      registered carry-out of bit 63
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high.
// - Reset:
//   - rst=1 forces Sum=64'h0 and Carry=0 immediately, without waiting for a clock edge.
//   - Both outputs hold 0 while rst stays high.
//   - Asserting rst mid-operation discards the pending result.
//   - The first result after rst is released comes from the first rising edge
//     with rst low.
// - Datapath:
//   - Combinational {c64, s[63:0]} = A + B + Cin, computed as 65-bit unsigned
//     addition.
//   - No overflow flag; signed overflow is detected by the ALU elsewhere.
//   - Per-bit full adder: s_i = a_i ^ b_i ^ c_i; g_i = a_i & b_i; p_i = a_i ^ b_i.
//   - Per group k (bits 4k..4k+3): group generate/propagate form the lookahead
//     carries c_{i+1} = g_i | p_i & c_i.
//   - Group carry-out feeds carry-in of group k+1; c0 = Cin; Carry = c64.
// - Timing and registers:
//   - Latency 1 cycle: inputs are sampled at rising edge N.
//   - Sum and Carry reflect those inputs from edge N until edge N+1.
//   - Inputs are not registered; only the outputs are flopped.
//   - Throughput is one addition per cycle, with no handshake and no stall input.
//   - Outputs change only on a rising clk edge or on rst assertion; input glitches
//     between edges have no effect.
// - Boundaries:
//   - Full wrap-around: all-ones + 0 with Cin=1 gives Sum=0, Carry=1.
//   - All-ones + all-ones with Cin=1 gives Sum=all-ones, Carry=1.
//   - X/Z on inputs need not be filtered.
// TESTING
// - Reset: drive rst=1 asynchronously mid-cycle with nonzero outputs
//   -> Sum=0, Carry=0 before the next edge.
// - A=64'h1234_5678_9ABC_DEF0, B=64'h8765_4321_0FED_CBA9, Cin=0
//   -> after 1 edge: Sum=64'h9999_9999_AAAA_AA99, Carry=0 (carry crosses a group boundary).
// - A=0, B=64'h1, Cin=0
//   -> Sum=64'h0000_0000_0000_0001, Carry=0.
// - A=64'h1111_1111_1111_1111, B=64'hFFFF_FFFF_FFFF_FFFF, Cin=0
//   -> Sum=64'h1111_1111_1111_1110, Carry=1.
// - A=64'hFFFF_FFFF_FFFF_FFFF, B=0, Cin=1
//   -> Sum=0, Carry=1 (full 64-bit ripple through all 16 groups).
// - Back-to-back: change A/B every cycle for 1000 random vectors
//   -> each output equals the 65-bit reference for the inputs of the previous
//      edge; no result is dropped or duplicated.

Source files
------------

// File: rtl/fa_64bit_sync.sv
// -----------------------------------------------------------------------------
// fa_64bit_sync
//   Registered 64-bit adder for the ALU execute stage: {Carry, Sum} = A + B + Cin,
//   captured on the rising clock edge so it lines up with the EX/MEM register.
//   The combinational core is a chain of 4-bit carry-lookahead groups. Each
//   group resolves its internal carries in parallel from bit generate/propagate
//   terms, and its carry-out ripples into the next group.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset; clears Sum and Carry
//   A      in   WIDTH  operand A (signedness-agnostic)
//   B      in   WIDTH  operand B
//   Cin    in   1      carry into bit 0
//   Sum    out  WIDTH  registered A + B + Cin, low WIDTH bits
//   Carry  out  1      registered carry out of the top bit
// -----------------------------------------------------------------------------
module fa_64bit_sync #(
  parameter int WIDTH = 64  // must be a multiple of 4; only 64 is verified
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;

  for (genvar k = 0; k < GROUPS; k++) begin : grp
    logic [3:0] g;     // bit generate
    logic [3:0] p;     // bit propagate
    logic [3:0] c;     // carry into each bit of the group
    logic       cin;
    logic       gg;    // group generate
    logic       gp;    // group propagate
    logic       cout;

    // Group 0 takes the external carry-in; every other group takes the
    // carry-out of the group below it.
    if (k == 0) begin : first
      assign cin = Cin;
    end else begin : chain
      assign cin = grp[k-1].cout;
    end

    assign g = A[4*k +: 4] & B[4*k +: 4];
    assign p = A[4*k +: 4] ^ B[4*k +: 4];

    // Lookahead: each internal carry is expanded from c_{i+1} = g_i | p_i & c_i
    // so all four resolve from cin in parallel instead of rippling bit by bit.
    assign c = {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cin,
                g[1] | p[1] & g[0] | p[1] & p[0] & cin,
                g[0] | p[0] & cin,
                cin};

    assign gg   = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
    assign gp   = &p;
    assign cout = gg | gp & cin;

    assign sum_c[4*k +: 4] = p ^ c;
  end

  assign carry_c = grp[GROUPS-1].cout;

  // Only the outputs are registered; A/B/Cin are sampled directly at the edge.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum   <= '0;
      Carry <= 1'b0;
    end else begin
      Sum   <= sum_c;
      Carry <= carry_c;
    end
  end

endmodule

// File: tb/tb_fa_64bit_sync.sv
// -----------------------------------------------------------------------------
// tb_fa_64bit_sync
//   Self-checking bench for fa_64bit_sync: a table of directed vectors with
//   hand-computed results, hand-written reset/hold/glitch sequences, and a
//   back-to-back run of random vectors against a 65-bit reference sum.
// -----------------------------------------------------------------------------
module tb_fa_64bit_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] A   = '0;
  logic [63:0] B   = '0;
  logic        Cin = 1'b0;
  logic [63:0] Sum;
  logic        Carry;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        carry;
  } vec_t;

  vec_t vecs [12];

  fa_64bit_sync #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Sum   (Sum),
    .Carry (Carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got carry=%0b sum=%016h, expected carry=%0b sum=%016h",
               name, act[64], act[63:0], exp[64], exp[63:0]);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic cin);
    A   = a;
    B   = b;
    Cin = cin;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] exp_prev;

    vecs[0]  = '{"group_cross",  64'h1234_5678_9ABC_DEF0, 64'h8765_4321_0FED_CBA9, 1'b0, 64'h9999_9999_AAAA_AA99, 1'b0};
    vecs[1]  = '{"zero_plus_one", 64'h0,                  64'h1,                  1'b0, 64'h0000_0000_0000_0001, 1'b0};
    vecs[2]  = '{"ones_b",       64'h1111_1111_1111_1111, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1111_1111_1111_1110, 1'b1};
    vecs[3]  = '{"full_wrap",    64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b1, 64'h0,                  1'b1};
    vecs[4]  = '{"ones_ones_c1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5]  = '{"cin_only",     64'h0,                  64'h0,                  1'b1, 64'h0000_0000_0000_0001, 1'b0};
    vecs[6]  = '{"nibble_cross", 64'h0000_0000_0000_000F, 64'h1,                  1'b0, 64'h0000_0000_0000_0010, 1'b0};
    vecs[7]  = '{"signed_edge",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                  1'b0, 64'h8000_0000_0000_0000, 1'b0};
    vecs[8]  = '{"msb_msb",      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0,                  1'b1};
    vecs[9]  = '{"ones_ones_c0", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[10] = '{"alt_bits_c1",  64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0,                  1'b1};
    vecs[11] = '{"half_wrap",    64'h0000_0000_FFFF_FFFF, 64'h0,                  1'b1, 64'h0000_0001_0000_0000, 1'b0};

    // Reset asserted with nonzero inputs: outputs clear with no clock edge.
    drive(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b1);
    rst = 1'b1;
    #2;
    check("reset_async_initial", {Carry, Sum}, 65'h0);
    @(posedge clk); #1;
    check("reset_hold_edge1", {Carry, Sum}, 65'h0);
    @(posedge clk); #1;
    check("reset_hold_edge2", {Carry, Sum}, 65'h0);

    // Release: first result comes from the first rising edge with rst low.
    @(negedge clk);
    rst = 1'b0;
    drive(64'h5, 64'h7, 1'b0);
    #1;
    check("release_before_edge", {Carry, Sum}, 65'h0);
    @(posedge clk); #1;
    check("release_first_result", {Carry, Sum}, {1'b0, 64'hC});

    // Directed table.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk); #1;
      check(vecs[i].name, {Carry, Sum}, {vecs[i].carry, vecs[i].sum});
    end

    // Input changes between edges must not reach the outputs.
    @(negedge clk);
    drive(64'h1, 64'h2, 1'b0);
    @(posedge clk); #2;
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    #1;
    check("glitch_hold_a", {Carry, Sum}, {1'b0, 64'h3});
    drive(64'h10, 64'h20, 1'b1);
    #3;
    check("glitch_hold_b", {Carry, Sum}, {1'b0, 64'h3});
    @(posedge clk); #1;
    check("glitch_last_sampled", {Carry, Sum}, {1'b0, 64'h31});

    // Mid-cycle async reset with nonzero outputs clears immediately.
    @(negedge clk);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    check("pre_reset_nonzero", {Carry, Sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    #2;
    rst = 1'b1;
    #1;
    check("reset_async_midcycle", {Carry, Sum}, 65'h0);

    // Pending inputs during reset are discarded.
    @(posedge clk); #1;
    check("reset_discard_pending", {Carry, Sum}, 65'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(64'h0000_0000_0000_00FF, 64'h1, 1'b0);
    @(posedge clk); #1;
    check("post_reset_result", {Carry, Sum}, {1'b0, 64'h100});

    // Back-to-back random vectors: at each falling edge the outputs must hold
    // the reference sum of the inputs sampled at the preceding rising edge.
    exp_prev = '0;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) check("random_b2b", {Carry, Sum}, exp_prev);
      if (i < 1000) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        drive(ra, rb, rc);
        exp_prev = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
